// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma_pkg
// Description : Shared mode codes, FSM state encoding and width defaults for
//               the banked-memory DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_dma_pkg;

    localparam int DMA_ADDR_W = 12;
    localparam int DMA_DATA_W = 8;
    localparam int DMA_LEN_W  = 13;

    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_SUM  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // The reserved code behaves exactly like a checksum.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_SUM : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma
// Description : Copy / fill / checksum engine driving the synchronous port of
//               the 4x1024x8 banked memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state, w_state_n;
    logic [1:0]          r_mode, w_mode;
    logic [ADDR_W-1:0]   r_src, w_src, w_src_nxt;
    logic [ADDR_W-1:0]   r_dst, w_dst, w_dst_nxt;
    logic [LEN_W-1:0]    r_cnt, w_cnt;
    logic [DATA_W-1:0]   r_fill, w_fill;
    logic [DATA_W-1:0]   r_acc, r_sum, r_wdata;
    logic                r_prev_re, r_cpw;
    logic                r_we, r_re, r_busy, r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_go, w_last, w_dec, w_add;
    logic                w_we_d, w_re_d, w_busy_d, w_done_d, w_cpw_d;
    logic [ADDR_W-1:0]   w_addr_d;
    logic [DATA_W-1:0]   w_wdata_d;

    // Operands come straight from the ports in the start cycle, else from latches.
    assign w_go      = (r_state == S_IDLE) && start;
    assign w_mode    = w_go ? norm_mode(mode) : r_mode;
    assign w_src     = w_go ? src_addr : r_src;
    assign w_dst     = w_go ? dst_addr : r_dst;
    assign w_cnt     = w_go ? len : r_cnt;
    assign w_fill    = w_go ? fill_val : r_fill;
    assign w_last    = (r_cnt == LEN_W'(1));
    assign w_dec     = (r_state == S_WRITE) || ((r_state == S_READ) && (r_mode == MODE_SUM));
    assign w_src_nxt = w_src + ADDR_W'(r_state == S_READ);
    assign w_dst_nxt = w_dst + ADDR_W'(r_state == S_WRITE);
    assign w_add     = r_prev_re && (r_mode == MODE_SUM) && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0)                w_state_n = S_FINISH;
                    else if (w_mode == MODE_FILL) w_state_n = S_WRITE;
                    else                          w_state_n = S_READ;
                end
            end
            S_READ: begin
                if (r_mode == MODE_COPY) w_state_n = S_WRITE;
                else if (w_last)         w_state_n = S_DRAIN;
            end
            S_WRITE: begin
                if (w_last)                   w_state_n = S_FINISH;
                else if (r_mode == MODE_COPY) w_state_n = S_READ;
            end
            S_DRAIN:  w_state_n = S_FINISH;
            S_FINISH: w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    // Next values of the registered memory-side and status outputs.
    always_comb begin
        w_re_d    = (w_state_n == S_READ);
        w_we_d    = (w_state_n == S_WRITE);
        w_busy_d  = (w_state_n == S_READ) || (w_state_n == S_WRITE) || (w_state_n == S_DRAIN);
        w_done_d  = (w_state_n == S_FINISH);
        w_cpw_d   = w_we_d && (w_mode == MODE_COPY);
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        if (w_re_d)      w_addr_d = w_src_nxt;
        else if (w_we_d) w_addr_d = w_dst_nxt;
        if (w_we_d && (w_mode == MODE_FILL)) w_wdata_d = w_fill;
        else if (r_cpw)                      w_wdata_d = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_COPY;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_wdata   <= '0;
            r_prev_re <= 1'b0;
            r_cpw     <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_mode    <= w_mode;
            r_src     <= w_src_nxt;
            r_dst     <= w_dst_nxt;
            r_cnt     <= w_cnt - LEN_W'(w_dec);
            r_fill    <= w_fill;
            r_wdata   <= w_wdata_d;
            r_prev_re <= r_re;
            r_cpw     <= w_cpw_d;
            r_we      <= w_we_d;
            r_re      <= w_re_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_addr    <= w_addr_d;
            if (w_go && (w_mode == MODE_SUM)) r_acc <= '0;
            else if (w_add)                   r_acc <= r_acc + mem_rdata;
            if ((r_state == S_DRAIN) && w_add) r_sum <= r_acc + mem_rdata;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign mem_we   = r_we;
    assign mem_re   = r_re;
    assign mem_addr = r_addr;
    // Copy writes forward the byte the memory returns this cycle from the prior read.
    assign mem_wdata = r_cpw ? mem_rdata : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dma
// Description : Self-checking bench for mem_dma with a behavioural memory and
//               an expected-write / expected-sum scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [11:0] src_addr, dst_addr;
    logic [12:0] len;
    logic [7:0]  fill_val;
    logic        busy, done, mem_we, mem_re;
    logic [7:0]  sum, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;

    logic [7:0]  mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a  = '0;
    logic [7:0]  pre_d  = '0;

    typedef struct {
        bit          is_sum;
        logic [11:0] a;
        logic [7:0]  d;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_dma dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .sum(sum),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pre_we)      mem[pre_a] <= pre_d;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Runs one operation; checks busy/done every cycle and every write against the scoreboard.
    task automatic op(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                      input logic [12:0] l, input logic [7:0] f, input int glitch);
        logic [1:0] mm;
        logic [7:0] acc;
        int exp_done, exp_reads, ovl, reads;
        exp_t e;
        mm = (m == 2'b11) ? 2'b10 : m;
        acc = 8'h00; ovl = 0; reads = 0;
        for (int i = 0; i < int'(l); i++) begin
            if (mm == 2'b00) sb.push_back('{1'b0, d + 12'(i), mem[s + 12'(i)]});
            if (mm == 2'b01) sb.push_back('{1'b0, d + 12'(i), f});
            if (mm == 2'b10) acc = acc + mem[s + 12'(i)];
        end
        if (mm == 2'b10 && l != 0) sb.push_back('{1'b1, 12'h000, acc});
        if (l == 0)          exp_done = 1;
        else if (mm == 2'b00) exp_done = 2 * int'(l) + 1;
        else if (mm == 2'b01) exp_done = int'(l) + 1;
        else                  exp_done = int'(l) + 2;
        exp_reads = (mm == 2'b01) ? 0 : int'(l);

        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= exp_done + 3; c++) begin
            check($sformatf("busy_c%0d", c), busy, (c < exp_done));
            check($sformatf("done_c%0d", c), done, (c == exp_done));
            if (mem_we && mem_re) ovl++;
            if (mem_re) reads++;
            if (mem_we) begin
                check("wr_expected", (sb.size() > 0) && !sb[0].is_sum, 1);
                if ((sb.size() > 0) && !sb[0].is_sum) begin
                    e = sb.pop_front();
                    check("wr_addr", mem_addr, e.a);
                    check("wr_data", mem_wdata, e.d);
                end
            end
            if (done && (sb.size() > 0) && sb[0].is_sum) begin
                e = sb.pop_front();
                check("sum", sum, e.d);
            end
            if (c == glitch) begin
                start = 1'b1; mode = 2'b01; dst_addr = 12'h900; len = 13'd5; fill_val = 8'h5A;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("overlap", ovl, 0);
        check("reads", reads, exp_reads);
        check("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; mode = 2'b00; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);

        poke(12'h010, 8'h11); poke(12'h011, 8'h22); poke(12'h012, 8'h33);
        poke(12'hFFE, 8'hFF); poke(12'hFFF, 8'h01); poke(12'h000, 8'h10); poke(12'h001, 8'h20);
        @(negedge clk);
        rst = 1'b0;

        op(2'b00, 12'h010, 12'h800, 13'd3, 8'h00, 0);
        check("copy_m800", mem[12'h800], 8'h11);
        check("copy_m801", mem[12'h801], 8'h22);
        check("copy_m802", mem[12'h802], 8'h33);

        op(2'b01, 12'h000, 12'h3FE, 13'd4, 8'hA5, 0);
        check("fill_m3fe", mem[12'h3FE], 8'hA5);
        check("fill_m3ff", mem[12'h3FF], 8'hA5);
        check("fill_m400", mem[12'h400], 8'hA5);
        check("fill_m401", mem[12'h401], 8'hA5);

        op(2'b10, 12'hFFE, 12'h000, 13'd4, 8'h00, 0);
        check("sum_hold", sum, 8'h30);
        op(2'b11, 12'hFFE, 12'h000, 13'd2, 8'h00, 0);
        check("sum_rsvd", sum, 8'h00);

        op(2'b00, 12'h010, 12'h700, 13'd0, 8'h00, 0);
        check("len0_sum_kept", sum, 8'h00);

        op(2'b00, 12'h010, 12'h820, 13'd3, 8'h00, 3);
        check("glitch_m820", mem[12'h820], 8'h11);
        check("glitch_m822", mem[12'h822], 8'h33);

        // Reset during a copy write cycle.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; src_addr = 12'h010; dst_addr = 12'hA00; len = 13'd3;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!mem_we && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_we", mem_we, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_re", mem_re, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_done", done, 0);
        end
        rst = 1'b0;

        op(2'b01, 12'h000, 12'hFFF, 13'd2, 8'h3C, 0);
        check("post_rst_mfff", mem[12'hFFF], 8'h3C);
        check("post_rst_m000", mem[12'h000], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
